// File: rtl/axi_id_serializer_pkg.sv
// Shared constants and helpers for the AXI ID serializer.
// The ID FIFOs are parameterised by width and pointer width only.
package axi_id_serializer_pkg;

   localparam int unsigned DefaultOutstandingWidth = 3;

   function automatic int unsigned fifo_depth(input int unsigned ptr_width);
      return 32'd1 << ptr_width;
   endfunction

endpackage

// File: rtl/axi_channel.sv
// Generic AXI4 channel bundle with master/slave modports.
interface axi_channel #(
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned AW_USER_WIDTH = 1,
   parameter int unsigned W_USER_WIDTH  = 1,
   parameter int unsigned B_USER_WIDTH  = 1,
   parameter int unsigned AR_USER_WIDTH = 1,
   parameter int unsigned R_USER_WIDTH  = 1
);

   logic [ID_WIDTH-1:0]      aw_id;
   logic [ADDR_WIDTH-1:0]    aw_addr;
   logic [7:0]               aw_len;
   logic [2:0]               aw_size;
   logic [1:0]               aw_burst;
   logic                     aw_lock;
   logic [3:0]               aw_cache;
   logic [2:0]               aw_prot;
   logic [3:0]               aw_qos;
   logic [AW_USER_WIDTH-1:0] aw_user;
   logic                     aw_valid;
   logic                     aw_ready;

   logic [DATA_WIDTH-1:0]    w_data;
   logic [DATA_WIDTH/8-1:0]  w_strb;
   logic                     w_last;
   logic [W_USER_WIDTH-1:0]  w_user;
   logic                     w_valid;
   logic                     w_ready;

   logic [ID_WIDTH-1:0]      b_id;
   logic [1:0]               b_resp;
   logic [B_USER_WIDTH-1:0]  b_user;
   logic                     b_valid;
   logic                     b_ready;

   logic [ID_WIDTH-1:0]      ar_id;
   logic [ADDR_WIDTH-1:0]    ar_addr;
   logic [7:0]               ar_len;
   logic [2:0]               ar_size;
   logic [1:0]               ar_burst;
   logic                     ar_lock;
   logic [3:0]               ar_cache;
   logic [2:0]               ar_prot;
   logic [3:0]               ar_qos;
   logic [AR_USER_WIDTH-1:0] ar_user;
   logic                     ar_valid;
   logic                     ar_ready;

   logic [ID_WIDTH-1:0]      r_id;
   logic [DATA_WIDTH-1:0]    r_data;
   logic [1:0]               r_resp;
   logic                     r_last;
   logic [R_USER_WIDTH-1:0]  r_user;
   logic                     r_valid;
   logic                     r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/axi_id_serializer_fifo.sv
// Synchronous ID FIFO with extra-MSB pointers; push when full and pop when empty are ignored.
module axi_id_serializer_fifo
   import axi_id_serializer_pkg::*;
#(
   parameter int unsigned Width    = 1,
   parameter int unsigned PtrWidth = DefaultOutstandingWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] din_i,
   output logic [Width-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned Depth = fifo_depth(PtrWidth);

   logic [PtrWidth:0]  wptr_q, wptr_d;
   logic [PtrWidth:0]  rptr_q, rptr_d;
   logic [Width-1:0]   mem_q [Depth];
   logic               push_ok;
   logic               pop_ok;

   assign full_o  = (wptr_q[PtrWidth] != rptr_q[PtrWidth]) &&
                    (wptr_q[PtrWidth-1:0] == rptr_q[PtrWidth-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rptr_q[PtrWidth-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + {{PtrWidth{1'b0}}, 1'b1};
      if (pop_ok)  rptr_d = rptr_q + {{PtrWidth{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q[PtrWidth-1:0]] <= din_i;
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
      else $error("ID FIFO overflow");

endmodule

// File: rtl/axi_id_serializer.sv
// Forwards every AW/AR with ID 0 and restores master IDs on B/R from per-direction FIFOs.
module axi_id_serializer
   import axi_id_serializer_pkg::*;
#(
   parameter int unsigned OUTSTANDING_WIDTH = DefaultOutstandingWidth
) (
   input logic        clk,
   input logic        rst,
   axi_channel.slave  master,
   axi_channel.master slave
);

   localparam int unsigned IdWidth = $bits(master.aw_id);

   if (($bits(master.aw_addr) != $bits(slave.aw_addr)) ||
       ($bits(master.ar_addr) != $bits(slave.ar_addr)) ||
       ($bits(master.w_data)  != $bits(slave.w_data))  ||
       ($bits(master.r_data)  != $bits(slave.r_data))  ||
       ($bits(master.aw_user) != $bits(slave.aw_user)) ||
       ($bits(master.w_user)  != $bits(slave.w_user))  ||
       ($bits(master.b_user)  != $bits(slave.b_user))  ||
       ($bits(master.ar_user) != $bits(slave.ar_user)) ||
       ($bits(master.r_user)  != $bits(slave.r_user))) begin : g_param_mismatch
      $fatal(1, "Parameter mismatch");
   end

   logic               wfifo_full, wfifo_empty, wfifo_push, wfifo_pop;
   logic               rfifo_full, rfifo_empty, rfifo_push, rfifo_pop;
   logic [IdWidth-1:0] wfifo_head, rfifo_head;
   logic               unused_slave_ids;

   // Slave-side IDs are always 0 on the way in, so returned IDs carry no information.
   assign unused_slave_ids = ^{slave.b_id, slave.r_id};

   // AW: gate on full so aw_ready never depends on b_ready.
   assign slave.aw_valid  = master.aw_valid && !wfifo_full;
   assign master.aw_ready = slave.aw_ready && !wfifo_full;
   assign slave.aw_id     = '0;
   assign slave.aw_addr   = master.aw_addr;
   assign slave.aw_len    = master.aw_len;
   assign slave.aw_size   = master.aw_size;
   assign slave.aw_burst  = master.aw_burst;
   assign slave.aw_lock   = master.aw_lock;
   assign slave.aw_cache  = master.aw_cache;
   assign slave.aw_prot   = master.aw_prot;
   assign slave.aw_qos    = master.aw_qos;
   assign slave.aw_user   = master.aw_user;
   assign wfifo_push      = master.aw_valid && master.aw_ready;

   assign slave.w_data    = master.w_data;
   assign slave.w_strb    = master.w_strb;
   assign slave.w_last    = master.w_last;
   assign slave.w_user    = master.w_user;
   assign slave.w_valid   = master.w_valid;
   assign master.w_ready  = slave.w_ready;

   assign master.b_id     = wfifo_head;
   assign master.b_resp   = slave.b_resp;
   assign master.b_user   = slave.b_user;
   assign master.b_valid  = slave.b_valid;
   assign slave.b_ready   = master.b_ready;
   assign wfifo_pop       = slave.b_valid && slave.b_ready;

   assign slave.ar_valid  = master.ar_valid && !rfifo_full;
   assign master.ar_ready = slave.ar_ready && !rfifo_full;
   assign slave.ar_id     = '0;
   assign slave.ar_addr   = master.ar_addr;
   assign slave.ar_len    = master.ar_len;
   assign slave.ar_size   = master.ar_size;
   assign slave.ar_burst  = master.ar_burst;
   assign slave.ar_lock   = master.ar_lock;
   assign slave.ar_cache  = master.ar_cache;
   assign slave.ar_prot   = master.ar_prot;
   assign slave.ar_qos    = master.ar_qos;
   assign slave.ar_user   = master.ar_user;
   assign rfifo_push      = master.ar_valid && master.ar_ready;

   // A read burst retires only on its last beat.
   assign master.r_id     = rfifo_head;
   assign master.r_data   = slave.r_data;
   assign master.r_resp   = slave.r_resp;
   assign master.r_last   = slave.r_last;
   assign master.r_user   = slave.r_user;
   assign master.r_valid  = slave.r_valid;
   assign slave.r_ready   = master.r_ready;
   assign rfifo_pop       = slave.r_valid && slave.r_ready && slave.r_last;

   axi_id_serializer_fifo #(
      .Width    (IdWidth),
      .PtrWidth (OUTSTANDING_WIDTH)
   ) u_wfifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (wfifo_push),
      .pop_i   (wfifo_pop),
      .din_i   (master.aw_id),
      .dout_o  (wfifo_head),
      .full_o  (wfifo_full),
      .empty_o (wfifo_empty)
   );

   axi_id_serializer_fifo #(
      .Width    (IdWidth),
      .PtrWidth (OUTSTANDING_WIDTH)
   ) u_rfifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (rfifo_push),
      .pop_i   (rfifo_pop),
      .din_i   (master.ar_id),
      .dout_o  (rfifo_head),
      .full_o  (rfifo_full),
      .empty_o (rfifo_empty)
   );

   a_b_not_empty : assert property (@(posedge clk) disable iff (rst)
      !(slave.b_valid && wfifo_empty))
      else $error("B response with no outstanding write");

   a_r_not_empty : assert property (@(posedge clk) disable iff (rst)
      !(slave.r_valid && slave.r_last && rfifo_empty))
      else $error("Last R beat with no outstanding read");

endmodule

// File: tb/tb_axi_id_serializer.sv
// Directed bench for axi_id_serializer: one depth-8 instance and one depth-4 instance.
`define TB_INIT_PAIR(M, S) \
   M.aw_valid = 0; M.aw_id = '0; M.aw_addr = '0; M.aw_len = '0; M.aw_size = 3'd2; \
   M.aw_burst = 2'b01; M.aw_lock = 0; M.aw_cache = '0; M.aw_prot = '0; M.aw_qos = '0; \
   M.aw_user = '0; M.w_valid = 0; M.w_data = '0; M.w_strb = '1; M.w_last = 0; M.w_user = '0; \
   M.b_ready = 0; M.ar_valid = 0; M.ar_id = '0; M.ar_addr = '0; M.ar_len = '0; \
   M.ar_size = 3'd2; M.ar_burst = 2'b01; M.ar_lock = 0; M.ar_cache = '0; M.ar_prot = '0; \
   M.ar_qos = '0; M.ar_user = '0; M.r_ready = 0; \
   S.aw_ready = 0; S.w_ready = 0; S.b_id = '1; S.b_resp = '0; S.b_user = '0; S.b_valid = 0; \
   S.ar_ready = 0; S.r_id = '1; S.r_data = '0; S.r_resp = '0; S.r_last = 0; S.r_user = '0; \
   S.r_valid = 0;

module tb_axi_id_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          exp_q[$];

   always #5 clk = ~clk;

   axi_channel #(.ID_WIDTH(4)) m_if ();
   axi_channel #(.ID_WIDTH(2)) s_if ();
   axi_channel #(.ID_WIDTH(4)) m2_if ();
   axi_channel #(.ID_WIDTH(2)) s2_if ();

   axi_id_serializer #(.OUTSTANDING_WIDTH(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .master (m_if.slave),
      .slave  (s_if.master)
   );

   axi_id_serializer #(.OUTSTANDING_WIDTH(2)) dut2 (
      .clk    (clk),
      .rst    (rst),
      .master (m2_if.slave),
      .slave  (s2_if.master)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued;
      int cyc;
      logic av, bv, acc;

      `TB_INIT_PAIR(m_if, s_if)
      `TB_INIT_PAIR(m2_if, s2_if)
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      s_if.aw_ready = 1'b1;
      #1;
      check_eq("rst_aw_ready", 32'(m_if.aw_ready), 1);
      check_eq("rst_wempty", 32'(dut.wfifo_empty), 1);
      check_eq("rst_rempty", 32'(dut.rfifo_empty), 1);

      // Single write, id 5
      m_if.aw_valid = 1'b1; m_if.aw_id = 4'd5; m_if.aw_addr = 32'h100;
      #1;
      check_eq("t1_s_aw_valid", 32'(s_if.aw_valid), 1);
      check_eq("t1_s_aw_id", 32'(s_if.aw_id), 0);
      check_eq("t1_s_aw_addr", s_if.aw_addr, 32'h100);
      check_eq("t1_m_aw_ready", 32'(m_if.aw_ready), 1);
      tick();
      m_if.aw_valid = 1'b0;
      m_if.w_valid = 1'b1; m_if.w_data = 32'hdeadbeef; m_if.w_last = 1'b1; s_if.w_ready = 1'b1;
      #1;
      check_eq("t1_w_data", s_if.w_data, 32'hdeadbeef);
      check_eq("t1_w_ready", 32'(m_if.w_ready), 1);
      check_eq("t1_wempty_busy", 32'(dut.wfifo_empty), 0);
      tick();
      m_if.w_valid = 1'b0;
      s_if.b_valid = 1'b1; s_if.b_resp = 2'b10; m_if.b_ready = 1'b1;
      #1;
      check_eq("t1_b_id", 32'(m_if.b_id), 5);
      check_eq("t1_b_resp", 32'(m_if.b_resp), 2);
      check_eq("t1_b_ready", 32'(s_if.b_ready), 1);
      tick();
      s_if.b_valid = 1'b0; s_if.b_resp = 2'b00;
      #1;
      check_eq("t1_wempty_done", 32'(dut.wfifo_empty), 1);

      // Depth-4 instance: fill with ids 1..4, fifth blocked until a B frees a slot
      s2_if.aw_ready = 1'b1; m2_if.b_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         m2_if.aw_valid = 1'b1; m2_if.aw_id = 4'(i);
         #1;
         check_eq("t2_aw_accept", 32'(m2_if.aw_ready), 1);
         tick();
      end
      m2_if.aw_id = 4'd5;
      #1;
      check_eq("t2_full_aw_ready", 32'(m2_if.aw_ready), 0);
      check_eq("t2_full_s_aw_valid", 32'(s2_if.aw_valid), 0);
      s2_if.b_valid = 1'b1;
      #1;
      check_eq("t2_b_id_oldest", 32'(m2_if.b_id), 1);
      check_eq("t2_no_popthrough", 32'(m2_if.aw_ready), 0);
      tick();
      s2_if.b_valid = 1'b0;
      #1;
      check_eq("t2_aw_ready_after_pop", 32'(m2_if.aw_ready), 1);
      tick();
      m2_if.aw_valid = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         s2_if.b_valid = 1'b1;
         #1;
         check_eq("t2_b_id_drain", 32'(m2_if.b_id), 32'(i));
         tick();
      end
      s2_if.b_valid = 1'b0;
      #1;
      check_eq("t2_wempty", 32'(dut2.wfifo_empty), 1);

      // Reads: id 7 (4 beats) then id 2 (1 beat)
      s_if.ar_ready = 1'b1;
      m_if.ar_valid = 1'b1; m_if.ar_id = 4'd7; m_if.ar_len = 8'd3;
      #1;
      check_eq("t3_s_ar_id", 32'(s_if.ar_id), 0);
      check_eq("t3_s_ar_len", 32'(s_if.ar_len), 3);
      tick();
      m_if.ar_id = 4'd2; m_if.ar_len = 8'd0;
      tick();
      m_if.ar_valid = 1'b0; m_if.r_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         s_if.r_valid = 1'b1; s_if.r_last = (b == 3); s_if.r_data = 32'hA0 + 32'(b);
         #1;
         check_eq("t3_r_id_burst", 32'(m_if.r_id), 7);
         check_eq("t3_r_data", m_if.r_data, 32'hA0 + 32'(b));
         tick();
      end
      s_if.r_last = 1'b1;
      #1;
      check_eq("t3_r_id_second", 32'(m_if.r_id), 2);
      check_eq("t3_r_last", 32'(m_if.r_last), 1);
      tick();
      s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
      #1;
      check_eq("t3_rempty", 32'(dut.rfifo_empty), 1);

      // Full depth-8 FIFO with AW and B in the same cycle
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         m_if.aw_valid = 1'b1; m_if.aw_id = 4'(i + 3);
         tick();
         exp_q.push_back(i + 3);
      end
      m_if.aw_id = 4'hE;
      #1;
      check_eq("t4_full", 32'(dut.wfifo_full), 1);
      check_eq("t4_full_aw_ready", 32'(m_if.aw_ready), 0);
      s_if.b_valid = 1'b1;
      #1;
      check_eq("t4_b_id", 32'(m_if.b_id), 32'(exp_q[0]));
      check_eq("t4_aw_blocked", 32'(m_if.aw_ready), 0);
      check_eq("t4_s_aw_valid", 32'(s_if.aw_valid), 0);
      tick();
      void'(exp_q.pop_front());
      s_if.b_valid = 1'b0;
      #1;
      check_eq("t4_aw_ready_next", 32'(m_if.aw_ready), 1);
      tick();
      exp_q.push_back(14);
      m_if.aw_valid = 1'b0;
      #1;
      check_eq("t4_full_again", 32'(dut.wfifo_full), 1);
      while (exp_q.size() > 0) begin
         s_if.b_valid = 1'b1;
         #1;
         check_eq("t4_b_id_drain", 32'(m_if.b_id), 32'(exp_q[0]));
         tick();
         void'(exp_q.pop_front());
      end
      s_if.b_valid = 1'b0;

      // 20 back-to-back writes with random B stalls; pointers wrap
      issued = 0;
      cyc = 0;
      while ((issued < 20 || exp_q.size() > 0) && cyc < 400) begin
         av = (issued < 20);
         bv = (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
         acc = av && (exp_q.size() < 8);
         m_if.aw_valid = av; m_if.aw_id = 4'(issued + 1); s_if.b_valid = bv;
         #1;
         if (av) check_eq("t5_aw_ready", 32'(m_if.aw_ready), 32'(acc));
         if (bv) check_eq("t5_b_id", 32'(m_if.b_id), 32'(exp_q[0]));
         tick();
         if (bv) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back((issued + 1) % 16);
            issued++;
         end
         cyc++;
      end
      m_if.aw_valid = 1'b0; s_if.b_valid = 1'b0;
      check_eq("t5_issued", 32'(issued), 20);
      check_eq("t5_left", 32'(exp_q.size()), 0);
      #1;
      check_eq("t5_wempty", 32'(dut.wfifo_empty), 1);

      // Reset with three writes outstanding
      for (int i = 0; i < 3; i++) begin
         m_if.aw_valid = 1'b1; m_if.aw_id = 4'(i + 1);
         tick();
      end
      m_if.aw_valid = 1'b0;
      #1;
      check_eq("t6_busy", 32'(dut.wfifo_empty), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_eq("t6_wempty", 32'(dut.wfifo_empty), 1);
      s_if.aw_ready = 1'b0; m_if.aw_valid = 1'b1; m_if.aw_id = 4'd9;
      #1;
      check_eq("t6_aw_ready_lo", 32'(m_if.aw_ready), 0);
      s_if.aw_ready = 1'b1;
      #1;
      check_eq("t6_aw_ready_hi", 32'(m_if.aw_ready), 1);
      tick();
      m_if.aw_valid = 1'b0; s_if.b_valid = 1'b1;
      #1;
      check_eq("t6_b_id", 32'(m_if.b_id), 9);
      tick();
      s_if.b_valid = 1'b0;
      #1;
      check_eq("t6_wempty_end", 32'(dut.wfifo_empty), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
